led_mode_decoder: RTL and testbench

- Receive-side counterpart of the bike light controller. It watches the single `led` drive waveform and recovers which mode the controller is in.
- Outputs the mode in the same one-hot encoding as the controller's state: [0]=OFF, [1]=ON, [2]=BLINK, [3]=DIM.
- Used as an on-chip monitor and as a self-checking companion in system benches.
- Classifies the waveform by duty and edge density over fixed windows. It reports a mode only after two consecutive windows agree.

---
 rtl/led_mode_decoder.sv | 120 ++++++++++++
 tb/tb_led_mode_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_mode_decoder.sv
// led_mode_decoder: recovers the bike light controller mode from its `led`
// drive waveform. Each window of N = 2^W cycles is classified by its high
// count (duty) and its rising-edge count. A mode is reported only when two
// consecutive windows agree on a legal classification.
module led_mode_decoder #(
  parameter int W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led,
  output logic [3:0] state,
  output logic       valid,
  output logic       changed,
  output logic       unknown
);

  localparam int N = 1 << W;

  // Classification thresholds, sized to match the W+1 bit counters.
  localparam logic [W:0] H_FULL     = (W+1)'(N);
  localparam logic [W:0] H_BLINK_LO = (W+1)'((3 * N) / 8);
  localparam logic [W:0] H_BLINK_HI = (W+1)'((5 * N) / 8);
  localparam logic [W:0] H_DIM_HI   = (W+1)'((7 * N) / 8);
  localparam logic [W:0] E_BLINK_HI = (W+1)'(N / 16);
  localparam logic [W:0] E_DIM_LO   = (W+1)'(N / 8);

  typedef enum logic [2:0] {
    CLS_OFF,
    CLS_ON,
    CLS_BLINK,
    CLS_DIM,
    CLS_INVALID
  } cls_t;

  logic [W-1:0] win_cnt;
  logic [W:0]   h_cnt;
  logic [W:0]   e_cnt;
  logic         prev_led;
  cls_t         cls;

  logic         window_end;
  logic [W:0]   h_next;
  logic [W:0]   e_next;
  cls_t         new_cls;
  logic [3:0]   new_onehot;
  logic         match;

  // Window ends on the last count; counts include this cycle's sample.
  always_comb begin
    window_end = &win_cnt;
    h_next     = h_cnt + (W+1)'(led);
    e_next     = e_cnt + (W+1)'(led & ~prev_led);
  end

  // Classify the window as it closes; the order of tests sets priority.
  always_comb begin
    new_cls = CLS_INVALID;
    if (h_next == '0) begin
      new_cls = CLS_OFF;
    end else if (h_next == H_FULL) begin
      new_cls = CLS_ON;
    end else if (h_next >= H_BLINK_LO && h_next <= H_BLINK_HI &&
                 e_next >= (W+1)'(1) && e_next <= E_BLINK_HI) begin
      new_cls = CLS_BLINK;
    end else if (h_next > H_BLINK_HI && h_next <= H_DIM_HI &&
                 e_next >= E_DIM_LO) begin
      new_cls = CLS_DIM;
    end
    match = (new_cls == cls) && (new_cls != CLS_INVALID);
  end

  // One-hot encoding shared with the controller's state register.
  always_comb begin
    new_onehot = 4'b0000;
    case (new_cls)
      CLS_OFF:   new_onehot = 4'b0001;
      CLS_ON:    new_onehot = 4'b0010;
      CLS_BLINK: new_onehot = 4'b0100;
      CLS_DIM:   new_onehot = 4'b1000;
      default:   new_onehot = 4'b0000;
    endcase
  end

  // Sample led every cycle; accumulate per window; latch decode at window end.
  // NOTE: state registers use non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      h_cnt    <= '0;
      e_cnt    <= '0;
      prev_led <= 1'b0;
      cls      <= CLS_INVALID;
      state    <= 4'b0000;
      valid    <= 1'b0;
      changed  <= 1'b0;
      unknown  <= 1'b0;
    end else begin
      win_cnt  <= win_cnt + 1'b1;
      prev_led <= led;
      changed  <= 1'b0;
      if (window_end) begin
        // Next window starts fresh with the next cycle's sample.
        h_cnt   <= '0;
        e_cnt   <= '0;
        cls     <= new_cls;
        unknown <= (new_cls == CLS_INVALID);
        valid   <= match;
        if (match) begin
          state   <= new_onehot;
          changed <= (new_onehot != state);
        end
      end else begin
        h_cnt <= h_next;
        e_cnt <= e_next;
      end
    end
  end

endmodule

// File: tb/tb_led_mode_decoder.sv
// tb_led_mode_decoder: directed checks of led_mode_decoder at W=5 (N=32).
// Cycle k is the k-th rising edge after reset release; outputs are sampled
// 1 ns after that edge.
module tb_led_mode_decoder;

  logic       clk;
  logic       rst_n;
  logic       led;
  logic [3:0] state;
  logic       valid;
  logic       changed;
  logic       unknown;

  int checks;
  int failures;

  led_mode_decoder #(.W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led    (led),
    .state  (state),
    .valid  (valid),
    .changed(changed),
    .unknown(unknown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] st, input logic v,
                           input logic c, input logic u);
    check({tag, ".state"},   state,            st);
    check({tag, ".valid"},   {3'b000, valid},   {3'b000, v});
    check({tag, ".changed"}, {3'b000, changed}, {3'b000, c});
    check({tag, ".unknown"}, {3'b000, unknown}, {3'b000, u});
  endtask

  // Drive one sample, let the DUT take it on the next rising edge.
  task automatic step(input logic v);
    led = v;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a few edges, release on a falling edge so the next
  // rising edge is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0;
    led   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    led      = 1'b0;

    // ---- OFF from reset, then a short pulse inside an OFF stream ----
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      step(1'b0);
      if (k == 32) check_out("off_w1", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (k == 64) check_out("off_w2", 4'b0001, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0); // cycle 65
    check_out("off_pulse_end", 4'b0001, 1'b1, 1'b0, 1'b0);
    // 5-cycle pulse in window 66..96 region: h=5, e=1 -> INVALID
    for (int k = 66; k <= 160; k++) begin
      step((k >= 70 && k <= 74) ? 1'b1 : 1'b0);
      if (k == 96)  check_out("pulse_w3", 4'b0001, 1'b0, 1'b0, 1'b1);
      if (k == 128) check_out("pulse_w4", 4'b0001, 1'b0, 1'b0, 1'b0);
      if (k == 160) check_out("pulse_w5", 4'b0001, 1'b1, 1'b0, 1'b0);
    end

    // ---- ON from reset, switch to OFF at cycle 80 ----
    do_reset();
    for (int k = 1; k <= 160; k++) begin
      step((k < 80) ? 1'b1 : 1'b0);
      if (k == 32)  check_out("on_w1", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (k == 64)  check_out("on_w2", 4'b0010, 1'b1, 1'b1, 1'b0);
      // window 65..96: h=15, e=0 -> INVALID, ON held
      if (k == 96)  check_out("sw_w3", 4'b0010, 1'b0, 1'b0, 1'b1);
      // window 97..128: OFF but previous window was INVALID
      if (k == 128) check_out("sw_w4", 4'b0010, 1'b0, 1'b0, 1'b0);
      if (k == 160) check_out("sw_w5", 4'b0001, 1'b1, 1'b1, 1'b0);
    end

    // ---- BLINK 8 high / 8 low, offset phase: rising edges at 5, 21, ... ----
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      step(((k + 3) >> 3) % 2 == 1);
      if (k == 32) check_out("blink_w1", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (k == 64) check_out("blink_w2", 4'b0100, 1'b1, 1'b1, 1'b0);
    end

    // ---- DIM 0,1,1,1 repeating: h=24, e=8 per window ----
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      step((k % 4) != 1);
      if (k == 32) check_out("dim_w1", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (k == 64) check_out("dim_w2", 4'b1000, 1'b1, 1'b1, 1'b0);
      if (k == 65) check_out("dim_hold", 4'b1000, 1'b1, 1'b0, 1'b0);
      if (k == 96) check_out("dim_w3", 4'b1000, 1'b1, 1'b0, 1'b0);
    end

    // ---- Async reset mid-window clears outputs immediately ----
    rst_n = 1'b0;
    #1;
    check_out("async_clr", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Partial counts discarded: OFF decodes exactly at cycle 64 again.
    for (int k = 1; k <= 64; k++) begin
      step(1'b0);
      if (k == 32) check_out("rst_off_w1", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (k == 64) check_out("rst_off_w2", 4'b0001, 1'b1, 1'b1, 1'b0);
    end

    // ---- Pseudo-random stream with reset pulse at cycle 50 ----
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      logic legal;
      step(1'($urandom_range(0, 1)));
      if (k == 50) begin
        rst_n = 1'b0;
        #1;
        check_out("rand_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      legal = (state == 4'b0000) || (state == 4'b0001) || (state == 4'b0010) ||
              (state == 4'b0100) || (state == 4'b1000);
      check("rand_onehot", {3'b000, legal}, 4'b0001);
      check("rand_valid_unknown", {3'b000, valid & unknown}, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
